// File: rtl/adau_init_sequencer.sv
// Walks a synchronous command ROM after a start pulse and turns WRITE entries into
// 32-bit ADAU SPI frames on a valid/ready stream; DELAY entries stall, END finishes.
module adau_init_sequencer #(
  parameter logic [6:0] CHIP_ADDR = 7'h00,
  parameter int         ROM_AW    = 6,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       data_out,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        error_code,
  output logic [ROM_AW:0]   frames_sent
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ROM_AW:0] FS_MAX = {1'b1, {ROM_AW{1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, SEND, WAIT, DONE, ERROR} state_t;

  state_t         state, next_state;
  logic [23:0]    delay_cnt;
  logic [TW-1:0]  timeout_cnt;
  logic [1:0]     opcode;
  logic           last_entry;
  logic           timed_out;
  logic           unused_rom_bits;

  assign opcode          = rom_data[31:30];
  assign last_entry      = &rom_addr;
  assign timed_out       = !ready && (timeout_cnt == TW'(TIMEOUT - 1));
  assign unused_rom_bits = ^rom_data[29:24];

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERROR: if (start) next_state = FETCH;
      FETCH:             next_state = DECODE;
      DECODE: begin
        case (opcode)
          2'b00: next_state = SEND;
          2'b01: begin
            if (rom_data[23:0] != 24'd0) next_state = WAIT;
            else                         next_state = last_entry ? DONE : FETCH;
          end
          2'b10:   next_state = DONE;
          default: next_state = ERROR;
        endcase
      end
      SEND: begin
        // A ready coinciding with the timeout still completes the handshake.
        if (ready)          next_state = last_entry ? DONE : FETCH;
        else if (timed_out) next_state = ERROR;
      end
      WAIT:    if (delay_cnt == 24'd1) next_state = last_entry ? DONE : FETCH;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    error = 1'b0;
    case (state)
      FETCH, DECODE, SEND, WAIT: busy  = 1'b1;
      DONE:                      done  = 1'b1;
      ERROR:                     error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      rom_addr    <= '0;
      data_out    <= '0;
      valid       <= 1'b0;
      error_code  <= 2'b00;
      frames_sent <= '0;
      delay_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            rom_addr    <= '0;
            frames_sent <= '0;
            error_code  <= 2'b00;
          end
        end
        DECODE: begin
          case (opcode)
            2'b00: begin
              data_out    <= {CHIP_ADDR, 1'b0, rom_data[23:8], rom_data[7:0]};
              valid       <= 1'b1;
              timeout_cnt <= '0;
            end
            2'b01: begin
              if (rom_data[23:0] != 24'd0) delay_cnt <= rom_data[23:0];
              else if (!last_entry)        rom_addr  <= rom_addr + ROM_AW'(1);
            end
            2'b11:   error_code <= 2'b10;
            default: ;
          endcase
        end
        SEND: begin
          if (ready) begin
            valid <= 1'b0;
            if (frames_sent != FS_MAX) frames_sent <= frames_sent + (ROM_AW+1)'(1);
            if (!last_entry)           rom_addr    <= rom_addr + ROM_AW'(1);
          end else if (timed_out) begin
            valid      <= 1'b0;
            error_code <= 2'b01;
          end else begin
            timeout_cnt <= timeout_cnt + TW'(1);
          end
        end
        WAIT: begin
          delay_cnt <= delay_cnt - 24'd1;
          if (delay_cnt == 24'd1 && !last_entry) rom_addr <= rom_addr + ROM_AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adau_init_sequencer.sv
// Directed bench: one instance with the default timeout, one with TIMEOUT=16.
module tb_adau_init_sequencer;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] rom [64];

  logic [5:0]  rom_addr, rom_addr_t;
  logic [31:0] rom_data, rom_data_t;
  logic [31:0] data_out, data_out_t;
  logic        valid, valid_t, busy, busy_t, done, done_t, error, error_t;
  logic [1:0]  error_code, error_code_t;
  logic [6:0]  frames_sent, frames_sent_t;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    rom_data   <= rom[rom_addr];
    rom_data_t <= rom[rom_addr_t];
  end

  adau_init_sequencer dut (
    .Clk(Clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .data_out(data_out), .valid(valid), .ready(ready), .busy(busy), .done(done),
    .error(error), .error_code(error_code), .frames_sent(frames_sent)
  );

  adau_init_sequencer #(.TIMEOUT(16)) dut_t (
    .Clk(Clk), .reset(reset), .start(start), .rom_addr(rom_addr_t), .rom_data(rom_data_t),
    .data_out(data_out_t), .valid(valid_t), .ready(ready), .busy(busy_t), .done(done_t),
    .error(error_t), .error_code(error_code_t), .frames_sent(frames_sent_t)
  );

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic load_basic_rom();
    foreach (rom[i]) rom[i] = 32'h0000_0000;
    rom[0] = 32'h0040_4001 & 32'h00FF_FFFF | 32'h0000_0000;
    rom[0] = 32'h0040_0001;
    rom[1] = 32'h0040_0220;
    rom[2] = 32'h8000_0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({valid, busy, done, error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {valid, busy, done, error});
    end
    checks++;
    if ({rom_addr, data_out, error_code, frames_sent} !== 47'd0) begin
      errors++;
      $display("FAIL reset_values: addr=%h data=%h code=%b frames=%0d expected all 0",
               rom_addr, data_out, error_code, frames_sent);
    end
    do_reset();
  endtask

  task automatic test_basic();
    load_basic_rom();
    ready = 1'b1;
    do_reset();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_fetch: busy=%b valid=%b expected busy=1 valid=0", busy, valid);
    end
    @(negedge Clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_decode_valid: got %b expected 0", valid);
    end
    @(negedge Clk);
    checks++;
    if (valid !== 1'b1 || data_out !== 32'h0040_0001) begin
      errors++;
      $display("FAIL basic_frame0: valid=%b data=%h expected valid=1 data=00400001", valid, data_out);
    end
    repeat (2) begin
      @(negedge Clk);
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_gap: valid=%b expected 0", valid);
      end
    end
    @(negedge Clk);
    checks++;
    if (valid !== 1'b1 || data_out !== 32'h0040_0220 || frames_sent !== 7'd1) begin
      errors++;
      $display("FAIL basic_frame1: valid=%b data=%h frames=%0d expected 1/00400220/1",
               valid, data_out, frames_sent);
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || frames_sent !== 7'd2 || valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b frames=%0d valid=%b expected 1/0/2/0",
               done, busy, frames_sent, valid);
    end
  endtask

  task automatic test_stall();
    bit held;
    load_basic_rom();
    ready = 1'b0;
    do_reset();
    pulse_start();
    repeat (2) @(negedge Clk);
    held = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (valid !== 1'b1 || data_out !== 32'h0040_0001) held = 1'b0;
      @(negedge Clk);
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: frame not held stable for 50 cycles, last valid=%b data=%h",
               valid, data_out);
    end
    ready = 1'b1;
    @(negedge Clk);
    checks++;
    if (valid !== 1'b0 || frames_sent !== 7'd1) begin
      errors++;
      $display("FAIL stall_handshake: valid=%b frames=%0d expected 0/1", valid, frames_sent);
    end
    for (int i = 0; i < 20 && !done; i++) @(negedge Clk);
    checks++;
    if (done !== 1'b1 || frames_sent !== 7'd2) begin
      errors++;
      $display("FAIL stall_done: done=%b frames=%0d expected 1/2", done, frames_sent);
    end
  endtask

  task automatic test_delay();
    int n;
    foreach (rom[i]) rom[i] = 32'h0000_0000;
    rom[0] = 32'h4000_0064;
    rom[1] = 32'h0040_0355;
    rom[2] = 32'h8000_0000;
    ready = 1'b1;
    do_reset();
    pulse_start();
    n = 1;
    while (!valid && n < 300) begin
      @(negedge Clk);
      n++;
    end
    // FETCH + DECODE of the DELAY, 100 WAIT cycles, FETCH + DECODE of the WRITE, then valid.
    checks++;
    if (n !== 105) begin
      errors++;
      $display("FAIL delay_latency: valid after %0d cycles expected 105", n);
    end
    checks++;
    if (data_out !== 32'h0040_0355) begin
      errors++;
      $display("FAIL delay_frame: got %h expected 00400355", data_out);
    end
  endtask

  task automatic test_timeout();
    int n;
    load_basic_rom();
    ready = 1'b0;
    do_reset();
    pulse_start();
    repeat (2) @(negedge Clk);
    n = 0;
    while (valid_t && n < 100) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL timeout_cycles: valid high %0d SEND cycles expected 16", n);
    end
    checks++;
    if (error_t !== 1'b1 || error_code_t !== 2'b01 || frames_sent_t !== 7'd0 || busy_t !== 1'b0) begin
      errors++;
      $display("FAIL timeout_status: error=%b code=%b frames=%0d busy=%b expected 1/01/0/0",
               error_t, error_code_t, frames_sent_t, busy_t);
    end
    ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 30 && !done_t; i++) @(negedge Clk);
    checks++;
    if (done_t !== 1'b1 || error_t !== 1'b0 || error_code_t !== 2'b00 || frames_sent_t !== 7'd2) begin
      errors++;
      $display("FAIL timeout_restart: done=%b error=%b code=%b frames=%0d expected 1/0/00/2",
               done_t, error_t, error_code_t, frames_sent_t);
    end
  endtask

  task automatic test_illegal();
    int vcount;
    foreach (rom[i]) rom[i] = 32'h0000_0000;
    rom[0] = 32'h0040_0001;
    rom[1] = 32'hC000_0000;
    ready = 1'b1;
    do_reset();
    pulse_start();
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid) vcount++;
      @(negedge Clk);
    end
    checks++;
    if (vcount !== 1) begin
      errors++;
      $display("FAIL illegal_valids: saw %0d valid cycles expected 1", vcount);
    end
    checks++;
    if (error !== 1'b1 || error_code !== 2'b10 || frames_sent !== 7'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_status: error=%b code=%b frames=%0d busy=%b expected 1/10/1/0",
               error, error_code, frames_sent, busy);
    end
  endtask

  task automatic test_reset_mid();
    load_basic_rom();
    ready = 1'b0;
    do_reset();
    pulse_start();
    repeat (2) @(negedge Clk);
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: valid=%b expected 1", valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({valid, busy, done, error} !== 4'b0000 || data_out !== 32'd0 || rom_addr !== 6'd0) begin
      errors++;
      $display("FAIL midreset_clear: valid=%b busy=%b data=%h addr=%h expected all 0",
               valid, busy, data_out, rom_addr);
    end
    @(negedge Clk);
    reset = 1'b0;
    ready = 1'b1;
    @(negedge Clk);
    pulse_start();
    repeat (2) @(negedge Clk);
    checks++;
    if (valid !== 1'b1 || data_out !== 32'h0040_0001) begin
      errors++;
      $display("FAIL midreset_resend: valid=%b data=%h expected 1/00400001", valid, data_out);
    end
  endtask

  initial begin
    foreach (rom[i]) rom[i] = 32'h0000_0000;
    @(negedge Clk);
    test_reset();
    test_basic();
    test_stall();
    test_delay();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
